axis_fifo_tx_scheduler: RTL

- Sequences the read side of the stream FIFO onto the AXI4-Stream master port.
- Cuts the beat stream into packets of a register-programmed length and asserts TLAST on each packet's final beat.
- Provides enable, flush and status for the AXI4-Lite register bank, which drives the cfg_* inputs and reads the stat_* outputs.
- Sits between the FIFO core (standard read, 1-cycle read latency) and the M_AXIS interface.

---
 rtl/axis_fifo_tx_scheduler_pkg.sv | 14 +
 rtl/axis_skid_buf2.sv | 57 +++++
 rtl/axis_fifo_tx_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/axis_fifo_tx_scheduler_pkg.sv
// Shared definitions for the stream FIFO transmit scheduler and its register bank.
package axis_fifo_tx_scheduler_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry FIFO-ordered holding buffer with push/pop/clear, for stream masters
// that must absorb read data still in flight when the sink stalls.
module axis_skid_buf2
    import axis_fifo_tx_scheduler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic              do_push;
    logic              do_pop;

    assign do_pop    = pop && (occ != 2'd0);
    assign do_push   = push && ((occ != 2'd2) || do_pop);
    assign head_data = ent0;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            occ <= 2'd0;
        end else if (do_push && !do_pop) begin
            occ <= occ + 2'd1;
        end else if (do_pop && !do_push) begin
            occ <= occ - 2'd1;
        end
    end

    // Entries carry no reset; occ alone says which of them hold live data.
    always_ff @(posedge clk) begin
        if (do_pop) begin
            ent0 <= ent1;
            if (do_push) begin
                if (occ == 2'd1) begin
                    ent0 <= push_data;
                end else begin
                    ent1 <= push_data;
                end
            end
        end else if (do_push) begin
            if (occ == 2'd0) begin
                ent0 <= push_data;
            end else begin
                ent1 <= push_data;
            end
        end
    end

endmodule

// File: rtl/axis_fifo_tx_scheduler.sv
// Drains the stream FIFO onto M_AXIS, cutting beats into packets of a programmed
// length with TLAST on each final beat; also handles flush and status.
module axis_fifo_tx_scheduler
    import axis_fifo_tx_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_enable,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    input  logic                  cfg_flush,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic [CNT_WIDTH-1:0]  stat_pkt_count,
    output logic                  stat_busy
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                  state;
    logic                    rd_vld_p1;
    logic [LEN_WIDTH-1:0]    len;
    logic [LEN_WIDTH-1:0]    beat_cnt;
    logic [LEN_WIDTH-1:0]    len_next;
    logic [1:0]              occ;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    pop;
    logic                    last_beat;
    logic                    flush_start;
    logic                    skid_push;

    assign len_next    = (cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len;
    assign last_beat   = (beat_cnt == (len - LEN_ONE));
    assign flush_start = (state == ST_IDLE) && cfg_flush;
    assign skid_push   = rd_vld_p1 && (state != ST_FLUSH);

    assign M_AXIS_TVALID = (state == ST_STREAM) && (occ != 2'd0);
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? head_data : '0;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && last_beat;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    assign stat_busy     = (state != ST_IDLE);

    // Keep buffered plus in-flight beats within the two skid entries.
    always_comb begin
        fifo_rd_en = 1'b0;
        case (state)
            ST_STREAM: fifo_rd_en = !fifo_empty &&
                                    (({1'b0, occ} + {2'b00, rd_vld_p1}) < (3'd2 + {2'b00, pop}));
            ST_FLUSH:  fifo_rd_en = !fifo_empty;
            default:   fifo_rd_en = 1'b0;
        endcase
    end

    axis_skid_buf2 #(
        .DATA_W(DATA_WIDTH)
    ) u_skid (
        .clk       (ACLK),
        .rst       (ARESET),
        .clr       (flush_start),
        .push      (skid_push),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state          <= ST_IDLE;
            rd_vld_p1      <= 1'b0;
            len            <= LEN_ONE;
            beat_cnt       <= '0;
            stat_pkt_count <= '0;
        end else begin
            rd_vld_p1 <= fifo_rd_en;
            case (state)
                ST_IDLE: begin
                    if (cfg_flush) begin
                        state <= ST_FLUSH;
                    end else if (cfg_enable) begin
                        state    <= ST_STREAM;
                        len      <= len_next;
                        beat_cnt <= '0;
                    end
                end
                ST_STREAM: begin
                    if (pop) begin
                        if (last_beat) begin
                            stat_pkt_count <= stat_pkt_count + CNT_ONE;
                            beat_cnt       <= '0;
                            if (cfg_enable) begin
                                len <= len_next;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + LEN_ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty && !rd_vld_p1 && (occ == 2'd0)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
